// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl
// Brief   : Data-memory controller between the MEM stage and a variable-latency
//           backing RAM (req/ack), with pipeline stall and fault reporting.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_ctrl #(
  parameter int N       = 64,
  parameter int AW      = 9,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  DM_addr,
  input  logic [N-1:0]  DM_writeData,
  input  logic          DM_writeEnable,
  input  logic          DM_readEnable,
  output logic [N-1:0]  DM_readData,
  output logic          stall,
  output logic          fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic          mem_ack,
  input  logic [N-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_COUNT_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_memAddr;
  logic [N-1:0]  r_memWdata;
  logic [N-1:0]  r_readData;
  logic          r_memWe;
  logic          r_timeout;
  logic [7:0]    r_count;

  logic w_valid;
  logic w_illegal;
  logic w_launch;
  logic w_expire;
  logic w_stall;
  logic w_fault;
  logic w_unusedBits;

  assign w_valid   = DM_readEnable | DM_writeEnable;
  assign w_illegal = w_valid & ((DM_addr[2:0] != 3'b000) | (DM_readEnable & DM_writeEnable));
  assign w_launch  = w_valid & ~w_illegal;
  assign w_expire  = ~mem_ack & (r_count == C_COUNT_LAST);

  // Upper address bits are deliberately dropped: the word address wraps.
  assign w_unusedBits = &{1'b0, DM_addr[N-1:AW+3]};

  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_nextState = REQ;
          w_stall     = 1'b1;
        end else if (w_illegal) begin
          w_fault     = 1'b1;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (mem_ack || w_expire) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_fault     = r_timeout;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memWe    <= 1'b0;
      r_readData <= '0;
      r_timeout  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_memAddr  <= DM_addr[AW+2:3];
            r_memWdata <= DM_writeData;
            r_memWe    <= DM_writeEnable;
            r_count    <= '0;
          end
        end
        REQ: begin
          r_count <= r_count + 8'd1;
          // An ack in the final allowed cycle still completes the access.
          if (mem_ack) begin
            if (!r_memWe) r_readData <= mem_rdata;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            if (!r_memWe) r_readData <= '0;
          end
        end
        DONE: begin
          r_timeout <= 1'b0;
        end
        default: begin
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  // Qualified by reset so an asserted reset silences the pipeline controls at once.
  assign stall       = reset & w_stall;
  assign fault       = reset & w_fault;
  assign mem_req     = (r_state == REQ);
  assign mem_we      = r_memWe;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign DM_readData = r_readData;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_ctrl
// Brief   : Scoreboard bench for dmem_ctrl (TIMEOUT shortened to 8).
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int N       = 64;
  localparam int AW      = 9;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  DM_addr = '0;
  logic [N-1:0]  DM_writeData = '0;
  logic          DM_writeEnable = 1'b0;
  logic          DM_readEnable = 1'b0;
  logic [N-1:0]  DM_readData;
  logic          stall;
  logic          fault;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_ack = 1'b0;
  logic [N-1:0]  mem_rdata = '0;

  int           checks   = 0;
  int           failures = 0;
  int           bursts   = 0;
  logic         prevReq  = 1'b0;
  logic [N-1:0] expRead  = '0;
  logic [N-1:0] expQ[$];

  dmem_ctrl #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .DM_addr(DM_addr), .DM_writeData(DM_writeData),
    .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
    .DM_readData(DM_readData), .stall(stall), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req && !prevReq) bursts++;
    prevReq = mem_req;
  end

  task automatic checkVal(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ackAt = REQ cycle on which mem_ack is raised; 0 means never (timeout).
  task automatic doAccess(input bit isRead, input logic [N-1:0] addr, input logic [N-1:0] data,
                          input logic [AW-1:0] expWord, input int ackAt);
    int  reqCnt   = 0;
    int  stallCnt = 0;
    bit  done     = 0;
    bit  acked    = (ackAt >= 1) && (ackAt <= TIMEOUT);
    int  expReq   = acked ? ackAt : TIMEOUT;
    if (isRead) expRead = acked ? data : '0;
    expQ.push_back(expRead);
    @(negedge clk);
    DM_addr        = addr;
    DM_writeData   = isRead ? '0 : data;
    DM_readEnable  = isRead;
    DM_writeEnable = !isRead;
    #1;
    checkVal("launchNoReq", N'(mem_req), '0);
    checkVal("launchStall", N'(stall), N'(1));
    checkVal("launchFault", N'(fault), '0);
    stallCnt = 1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        reqCnt++;
        checkVal("memAddr", N'(mem_addr), N'(expWord));
        checkVal("memWe", N'(mem_we), N'(!isRead));
        if (!isRead) checkVal("memWdata", mem_wdata, data);
        checkVal("reqStall", N'(stall), N'(1));
        if (stall) stallCnt++;
        mem_ack   = (reqCnt == ackAt);
        mem_rdata = (reqCnt == ackAt) ? data : 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        mem_ack = 1'b0;
        done    = 1;
        checkVal("doneStall", N'(stall), '0);
        checkVal("doneFault", N'(fault), N'(!acked));
        checkVal("readData", DM_readData, expQ.pop_front());
        checkVal("reqCycles", N'(reqCnt), N'(expReq));
        checkVal("stallCycles", N'(stallCnt), N'(expReq + 1));
      end
    end
    checkVal("doneReached", N'(done), N'(1));
  endtask

  task automatic clearInputs();
    @(negedge clk);
    DM_readEnable  = 1'b0;
    DM_writeEnable = 1'b0;
    mem_ack        = 1'b0;
    #1;
    checkVal("idleNoReq", N'(mem_req), '0);
    checkVal("idleStall", N'(stall), '0);
  endtask

  task automatic doIllegal(input logic [N-1:0] addr, input bit re, input bit we);
    @(negedge clk);
    DM_addr        = addr;
    DM_readEnable  = re;
    DM_writeEnable = we;
    #1;
    checkVal("illFault", N'(fault), N'(1));
    checkVal("illStall", N'(stall), '0);
    checkVal("illNoReq", N'(mem_req), '0);
    @(negedge clk);
    DM_readEnable  = 1'b0;
    DM_writeEnable = 1'b0;
    #1;
    checkVal("illAfterReq", N'(mem_req), '0);
    checkVal("illAfterFault", N'(fault), '0);
  endtask

  initial begin
    int b0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("rstReadData", DM_readData, '0);
    checkVal("rstReq", N'(mem_req), '0);
    checkVal("rstWe", N'(mem_we), '0);
    checkVal("rstAddr", N'(mem_addr), '0);
    checkVal("rstWdata", mem_wdata, '0);
    checkVal("rstStall", N'(stall), '0);
    checkVal("rstFault", N'(fault), '0);
    @(negedge clk);
    reset = 1'b1;

    doAccess(1'b1, 64'h10, 64'hDEADBEEF, 9'd2, 1);
    clearInputs();
    doAccess(1'b0, 64'h18, 64'h1234, 9'd3, 3);
    clearInputs();

    doIllegal(64'h13, 1'b1, 1'b0);
    doIllegal(64'h20, 1'b1, 1'b1);

    doAccess(1'b1, 64'h40, 64'h5555_AAAA, 9'd8, 0);
    clearInputs();
    doAccess(1'b1, 64'h1028, 64'hCAFE_F00D, 9'd5, 2);
    clearInputs();

    // Reset asserted in the middle of an outstanding request.
    @(negedge clk);
    DM_addr       = 64'h30;
    DM_readEnable = 1'b1;
    @(negedge clk);
    #1;
    checkVal("rstMidReq1", N'(mem_req), N'(1));
    @(negedge clk);
    #1;
    checkVal("rstMidReq2", N'(mem_req), N'(1));
    reset = 1'b0;
    #1;
    checkVal("rstDropReq", N'(mem_req), '0);
    checkVal("rstDropStall", N'(stall), '0);
    checkVal("rstDropData", DM_readData, '0);
    expRead       = '0;
    DM_readEnable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkVal("rstRelReq", N'(mem_req), '0);
    doAccess(1'b1, 64'h08, 64'h0BAD_CAFE, 9'd1, 1);
    clearInputs();

    b0 = bursts;
    doAccess(1'b1, 64'h00, 64'h1111_2222, 9'd0, 2);
    doAccess(1'b1, 64'h08, 64'h3333_4444, 9'd1, 1);
    clearInputs();
    repeat (2) @(negedge clk);
    checkVal("b2bBursts", N'(bursts - b0), N'(2));
    checkVal("queueEmpty", N'(expQ.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
